bq_fet_sequencer: RTL and testbench

//   Sequences the CHG/DSG/PCHG/PDSG FET drives of the BQ76952 pack model.

---
 rtl/bq_fet_pkg.sv | 14 +
 rtl/bq_sat_counter.sv | 27 ++
 rtl/bq_fet_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_bq_fet_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bq_fet_pkg.sv
// rtl/bq_fet_pkg.sv - shared types and widths for the BQ76952 FET sequencer
package bq_fet_pkg;
  localparam int MV_W  = 16;
  localparam int CUR_W = 16;

  typedef enum logic [2:0] {
    S_OFF,
    S_PDSG,
    S_PCHG,
    S_ON,
    S_FAULT,
    S_LATCHED
  } state_e;
endpackage

// File: rtl/bq_sat_counter.sv
// rtl/bq_sat_counter.sv - saturating up-counter with clear priority and done flag
module bq_sat_counter #(
  parameter  int LIMIT = 10,
  localparam int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         done_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != W'(LIMIT))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == W'(LIMIT));
endmodule

// File: rtl/bq_fet_sequencer.sv
// rtl/bq_fet_sequencer.sv - CHG/DSG/PCHG/PDSG FET sequencing with PTO, recovery and latch-off
// Optional predischarge stage enabled by defining BQ_PDSG_EN.
module bq_fet_sequencer
  import bq_fet_pkg::*;
#(
  parameter int PCHG_START_MV = 2500,
  parameter int PCHG_STOP_MV  = 3000,
  parameter int PTO_CURR      = 50,
  parameter int PTO_LIMIT     = 100,
  parameter int RECOV_CYCLES  = 20,
  parameter int LATCH_LIMIT   = 3,
  parameter int DECAY_CYCLES  = 200,
  parameter int PDSG_CYCLES   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    fault_chg,
  input  logic                    fault_dsg,
  input  logic [MV_W-1:0]         min_cell_mv,
  input  logic signed [CUR_W-1:0] current,
  input  logic                    ld,
  input  logic                    clear_latch,
  output logic                    chg_on,
  output logic                    dsg_on,
  output logic                    pchg_on,
  output logic                    pdsg_on,
  output logic                    pto_alert,
  output logic                    ptos_error,
  output logic                    latched,
  output logic                    alert
);
  localparam int LW = $clog2(LATCH_LIMIT + 1);

  state_e state_q, state_d;
  logic   seen_chg_q, seen_chg_d, seen_dsg_q, seen_dsg_d, ptos_q, ptos_d;
  logic   pto_inc, pto_clr, pto_done, recov_inc, recov_clr, recov_done;
  logic   decay_inc, decay_clr, decay_done, latch_inc, latch_clr, latch_done;
  logic   latch_hit, any_fault, min_low, min_ok, cur_hi;
  logic [LW-1:0]                     latch_cnt;
  logic [$clog2(PTO_LIMIT+1)-1:0]    pto_cnt_unused;
  logic [$clog2(RECOV_CYCLES+1)-1:0] recov_cnt_unused;
  logic [$clog2(DECAY_CYCLES+1)-1:0] decay_cnt_unused;

  assign any_fault = fault_chg | fault_dsg;
  assign min_low   = (min_cell_mv < MV_W'(PCHG_START_MV));
  assign min_ok    = (min_cell_mv >= MV_W'(PCHG_STOP_MV));
  assign cur_hi    = (current > $signed(CUR_W'(PTO_CURR)));
  // The entry that brings latch_cnt up to LATCH_LIMIT goes straight to S_LATCHED.
  assign latch_hit = latch_done || (latch_cnt == LW'(LATCH_LIMIT - 1));

`ifdef BQ_PDSG_EN
  logic pdsg_done;
  logic [$clog2(PDSG_CYCLES)-1:0] pdsg_cnt_unused;
  // Limit is one short so pdsg_on stays high for exactly PDSG_CYCLES cycles.
  bq_sat_counter #(.LIMIT(PDSG_CYCLES - 1)) u_pdsg_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(state_q == S_PDSG), .clr_i(state_d != S_PDSG),
    .cnt_o(pdsg_cnt_unused), .done_o(pdsg_done)
  );
`else
  logic ld_unused;
  assign ld_unused = ld;
  assign pdsg_on   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    seen_chg_d = seen_chg_q;
    seen_dsg_d = seen_dsg_q;
    ptos_d     = ptos_q;
    latch_inc  = 1'b0;
    latch_clr  = 1'b0;
    if (state_q == S_LATCHED) begin
      if (clear_latch) begin
        state_d   = S_OFF;
        ptos_d    = 1'b0;
        latch_clr = 1'b1;
      end
    end else if (!en) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF: begin
          if (min_low) state_d = S_PCHG;
`ifdef BQ_PDSG_EN
          else if (ld) state_d = S_PDSG;
`endif
          else state_d = S_ON;
        end
`ifdef BQ_PDSG_EN
        S_PDSG: begin
          if (any_fault) begin
            state_d   = latch_hit ? S_LATCHED : S_FAULT;
            latch_inc = 1'b1;
          end else if (pdsg_done) begin
            state_d = S_ON;
          end
        end
`endif
        S_PCHG: begin
          if (pto_done) begin
            state_d = S_LATCHED;
            ptos_d  = 1'b1;
          end else if (any_fault) begin
            state_d   = latch_hit ? S_LATCHED : S_FAULT;
            latch_inc = 1'b1;
          end else if (min_ok) begin
            state_d = S_ON;
          end
        end
        S_ON: begin
          if (any_fault) begin
            state_d   = latch_hit ? S_LATCHED : S_FAULT;
            latch_inc = 1'b1;
          end else if (min_low) begin
            state_d = S_PCHG;
          end
        end
        S_FAULT: begin
          if (!any_fault && recov_done) state_d = S_ON;
        end
        default: state_d = S_OFF;
      endcase
      if ((state_q == S_ON) && decay_done && !latch_inc) latch_clr = 1'b1;
    end
    if (state_d == S_FAULT) begin
      seen_chg_d = seen_chg_q | fault_chg;
      seen_dsg_d = seen_dsg_q | fault_dsg;
    end else begin
      seen_chg_d = 1'b0;
      seen_dsg_d = 1'b0;
    end
  end

  assign pto_inc   = (state_q == S_PCHG) && cur_hi;
  assign pto_clr   = (state_d != S_PCHG);
  assign recov_inc = (state_q == S_FAULT);
  assign recov_clr = (state_d != S_FAULT) || any_fault;
  assign decay_inc = (state_q == S_ON);
  assign decay_clr = (state_d != S_ON) || any_fault;

  bq_sat_counter #(.LIMIT(PTO_LIMIT)) u_pto_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(pto_inc), .clr_i(pto_clr),
    .cnt_o(pto_cnt_unused), .done_o(pto_done)
  );
  bq_sat_counter #(.LIMIT(RECOV_CYCLES)) u_recov_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(recov_inc), .clr_i(recov_clr),
    .cnt_o(recov_cnt_unused), .done_o(recov_done)
  );
  bq_sat_counter #(.LIMIT(DECAY_CYCLES)) u_decay_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(decay_inc), .clr_i(decay_clr),
    .cnt_o(decay_cnt_unused), .done_o(decay_done)
  );
  bq_sat_counter #(.LIMIT(LATCH_LIMIT)) u_latch_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(latch_inc), .clr_i(latch_clr),
    .cnt_o(latch_cnt), .done_o(latch_done)
  );

  // Outputs decode the next state so they change on the same edge as state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      seen_chg_q <= 1'b0;
      seen_dsg_q <= 1'b0;
      ptos_q     <= 1'b0;
      chg_on     <= 1'b0;
      dsg_on     <= 1'b0;
      pchg_on    <= 1'b0;
      pto_alert  <= 1'b0;
      ptos_error <= 1'b0;
      latched    <= 1'b0;
      alert      <= 1'b0;
`ifdef BQ_PDSG_EN
      pdsg_on    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      seen_chg_q <= seen_chg_d;
      seen_dsg_q <= seen_dsg_d;
      ptos_q     <= ptos_d;
      chg_on     <= (state_d == S_ON) || ((state_d == S_FAULT) && !seen_chg_d);
      dsg_on     <= (state_d == S_ON) || (state_d == S_PCHG) ||
                    ((state_d == S_FAULT) && !seen_dsg_d);
      pchg_on    <= (state_d == S_PCHG);
      pto_alert  <= (state_d == S_PCHG);
      ptos_error <= ptos_d;
      latched    <= (state_d == S_LATCHED);
      alert      <= ptos_d || (state_d == S_LATCHED) || (state_d == S_FAULT);
`ifdef BQ_PDSG_EN
      pdsg_on    <= (state_d == S_PDSG);
`endif
    end
  end
endmodule

// File: tb/tb_bq_fet_sequencer.sv
// tb/tb_bq_fet_sequencer.sv - directed self-checking bench for bq_fet_sequencer
module tb_bq_fet_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, fault_chg, fault_dsg, ld, clear_latch;
  logic [15:0] min_cell_mv;
  logic signed [15:0] current;
  logic        chg_on, dsg_on, pchg_on, pdsg_on;
  logic        pto_alert, ptos_error, latched, alert;
  int          checks = 0;
  int          errors = 0;

  bq_fet_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fault_chg(fault_chg), .fault_dsg(fault_dsg),
    .min_cell_mv(min_cell_mv), .current(current), .ld(ld), .clear_latch(clear_latch),
    .chg_on(chg_on), .dsg_on(dsg_on), .pchg_on(pchg_on), .pdsg_on(pdsg_on),
    .pto_alert(pto_alert), .ptos_error(ptos_error), .latched(latched), .alert(alert)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // fets = {chg,dsg,pchg,pdsg}; status = {pto_alert,ptos_error,latched,alert}
  task automatic check_fets(input string tag, input logic [3:0] exp);
    check(tag, {chg_on, dsg_on, pchg_on, pdsg_on}, exp);
  endtask

  task automatic check_status(input string tag, input logic [3:0] exp);
    check(tag, {pto_alert, ptos_error, latched, alert}, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; fault_chg = 1'b0; fault_dsg = 1'b0; ld = 1'b0; clear_latch = 1'b0;
    min_cell_mv = 16'd4000; current = 16'sd0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    check_fets("reset_fets", 4'b0000);
    check_status("reset_status", 4'b0000);

    en = 1'b1;
    tick(1);
    check_fets("t1_on", 4'b1100);
    en = 1'b0;
    tick(1);
    check_fets("en_low_off", 4'b0000);
    min_cell_mv = 16'd2500;
    en = 1'b1;
    tick(1);
    check_fets("min_2500_on", 4'b1100);

    fault_chg = 1'b1;
    tick(1);
    check_fets("t3_fault", 4'b0100);
    check_status("t3_alert", 4'b0001);
    tick(2);
    check_fets("t3_fault_held", 4'b0100);
    fault_chg = 1'b0;
    tick(20);
    check_fets("t3_recov_20", 4'b0100);
    tick(1);
    check_fets("t3_recovered", 4'b1100);
    check_status("t3_alert_clear", 4'b0000);

    do_reset();
    en = 1'b1;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      fault_chg = 1'b1;
      tick(1);
      fault_chg = 1'b0;
      tick(21);
      check_fets("t4_episode_on", 4'b1100);
    end
    fault_chg = 1'b1;
    tick(1);
    fault_chg = 1'b0;
    check_status("t4_latched", 4'b0011);
    check_fets("t4_latched_fets", 4'b0000);
    en = 1'b0;
    tick(1);
    check_status("t4_en_low_stays", 4'b0011);
    en = 1'b1;
    clear_latch = 1'b1;
    tick(1);
    clear_latch = 1'b0;
    check_status("t4_cleared", 4'b0000);
    check_fets("t4_cleared_off", 4'b0000);
    tick(1);
    check_fets("t4_back_on", 4'b1100);
    for (int i = 0; i < 3; i++) begin
      fault_chg = 1'b1;
      tick(1);
      fault_chg = 1'b0;
      check_status("t4_spaced_no_latch", 4'b0001);
      tick(21);
      tick(250);
    end
    check_fets("t4_spaced_on", 4'b1100);

    do_reset();
    min_cell_mv = 16'd2400;
    current = 16'sd51;
    en = 1'b1;
    tick(1);
    check_fets("t2_pchg_fets", 4'b0110);
    check_status("t2_pto_alert", 4'b1000);
    tick(100);
    check_status("t2_count_100", 4'b1000);
    tick(1);
    check_status("t2_ptos", 4'b0111);
    check_fets("t2_ptos_fets", 4'b0000);
    clear_latch = 1'b1;
    tick(1);
    clear_latch = 1'b0;
    check_status("t2_cleared", 4'b0000);
    check_fets("t2_cleared_off", 4'b0000);

    do_reset();
    min_cell_mv = 16'd2400;
    current = 16'sd50;
    en = 1'b1;
    tick(151);
    check_status("pto_curr_50_no_count", 4'b1000);
    current = -16'sd200;
    tick(150);
    check_status("pto_negative_no_count", 4'b1000);
    min_cell_mv = 16'd3000;
    tick(1);
    check_fets("pchg_exit_3000", 4'b1100);
    check_status("pchg_exit_status", 4'b0000);

    do_reset();
    min_cell_mv = 16'd2400;
    current = 16'sd51;
    en = 1'b1;
    tick(100);
    min_cell_mv = 16'd3000;
    fault_dsg = 1'b1;
    tick(1);
    fault_dsg = 1'b0;
    check_fets("t5_fault_fets", 4'b1000);
    check_status("t5_fault_status", 4'b0001);

`ifdef BQ_PDSG_EN
    do_reset();
    ld = 1'b1;
    en = 1'b1;
    tick(1);
    check_fets("t6_pdsg_start", 4'b0001);
    tick(9);
    check_fets("t6_pdsg_last", 4'b0001);
    tick(1);
    check_fets("t6_pdsg_done", 4'b1100);
    do_reset();
    ld = 1'b1;
    en = 1'b1;
    tick(3);
    en = 1'b0;
    tick(1);
    check_fets("t6_en_low_mid_pdsg", 4'b0000);
`else
    do_reset();
    ld = 1'b1;
    en = 1'b1;
    tick(1);
    check_fets("pdsg_disabled_on", 4'b1100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
